lane_hit_judge: RTL
===================

// Module: lane_hit_judge
// PURPOSE
//  Rhythm-game judge downstream of the region smoother: consumes the per-frame debounced
//  4-lane green-region flags plus the falling-note positions and decides hit / miss / ghost per lane.
//  Drives score, combo, note-consume pulses and per-lane flash flags to the note generator and
//  shape-drawing stage. Evaluates once per video frame, lanes serially, all on the VGA clock.
// PARAMETERS
//  Y_W           10    width of one note y coordinate (pixels)
//  HIT_Y_MIN     400   lowest y (inclusive) of the hit window
//  HIT_Y_MAX     460   highest y (inclusive); note_y > HIT_Y_MAX = missed note
//  SCORE_W       16    score width
//  COMBO_W       8     combo width
//  FLASH_FRAMES  8     frames a hit/miss flash stays asserted (>=1)
//  PERF_Y_MIN    425   perfect sub-window low bound (used only with JUDGE_PERFECT_EN)
//  PERF_Y_MAX    435   perfect sub-window high bound (used only with JUDGE_PERFECT_EN)
// PORTS
//  CLOCK_25      in   1        sole clock; all logic on rising edge
//  rst           in   1        synchronous, active-high reset
//  frame_tick    in   1        1-cycle pulse, once per frame (start of vertical blank)
//  en_regions    in   1        region flags valid this frame
//  green_region  in   4        debounced lane-pressed flags, bit i = lane i
//  note_valid    in   4        lane i has a live note
//  note_y        in   4*Y_W    lane i note y at [i*Y_W +: Y_W]
//  note_consume  out  4        1-cycle pulse: lane i note hit or missed, generator retires it
//  score         out  SCORE_W  accumulated score
//  combo         out  COMBO_W  consecutive hits
//  hit_flash     out  4        lane i hit indicator
//  miss_flash    out  4        lane i miss indicator
//  busy          out  1        evaluation in progress
//  overrun       out  1        sticky: frame_tick arrived while busy
// BEHAVIOUR
//  Reset: every output 0, prev_region=0, flash counters 0, FSM=IDLE; rst wins over all else,
//   including mid-evaluation (partial updates of that frame are discarded, no pulses after).
//  FSM: IDLE -(frame_tick)-> SAMPLE -> EVAL(lane=0..3, one cycle each) -> DONE -> IDLE.
//  SAMPLE (cycle t+1 after tick at t): latch reg = en_regions ? green_region : 4'b0,
//   latch note_valid/note_y; press = reg & ~prev_region; prev_region <= reg; decrement every
//   nonzero flash counter by 1; busy=1 from t+1 through DONE.
//  EVAL lane i (cycle t+2+i), first match wins:
//   1 HIT: press[i] & valid[i] & HIT_Y_MIN<=y<=HIT_Y_MAX -> score += 10 + combo (zero-ext,
//     saturate at 2^SCORE_W-1), combo += 1 (saturate at 2^COMBO_W-1), consume[i], hit cnt=FLASH_FRAMES.
//   2 MISS: valid[i] & y>HIT_Y_MAX -> combo=0, consume[i], miss cnt=FLASH_FRAMES.
//   3 GHOST: press[i] & no in-window note -> combo=0, no consume, no flash.
//   4 else nothing. Score add uses combo value before this lane's increment.
//  note_consume[i] registered: high exactly cycle t+3+i; score/combo visible from t+3+i.
//  DONE at t+6, busy low from t+7; next tick accepted from t+7.
//  hit_flash[i]=(hit cnt!=0), miss_flash[i]=(miss cnt!=0); a new hit clears lane miss cnt and vice versa.
//  frame_tick while busy: ignored, overrun<=1 (cleared only by rst).
//  Held press across frames scores once (edge only); en_regions low counts as release.
// CONFIGURATION
//  JUDGE_PERFECT_EN defined: HIT with PERF_Y_MIN<=y<=PERF_Y_MAX adds extra +10 (total 20+combo,
//   same saturation); extra output perfect_flash[3:0] uses the hit flash counter rule.
//  Undefined: all in-window hits score 10+combo; perfect_flash port absent.
// TESTING
//  rst then idle 100 cycles -> all outputs 0, busy 0, no consume pulses.
//  Lane0 note y=430, green_region=0001, en=1, tick -> consume=0001 at t+3, score=10, combo=1, hit_flash[0]=1 for 8 ticks.
//  Hold 0001 next frame with new note y=410 -> no hit (no edge), combo stays 1; release 1 frame, press -> score=10+10+1=21, combo=2.
//  combo=5, lane2 note y=461 no press -> consume=0100 at t+5, combo=0, miss_flash[2]=1, score unchanged.
//  Lanes 0..3 all in-window and pressed, combo=0 -> consume pulses t+3..t+6, score +10+11+12+13=46, combo=4.
//  score=65530, combo=255, hit -> score=65535, combo=255; tick at t+3 -> overrun=1; rst at t+4 -> all 0, no later pulse.

Source files
------------

// File: rtl/lane_hit_judge.sv
// Per-frame rhythm-game judge: samples the four lane press flags once per frame, then judges
// hit / miss / ghost one lane per cycle. Optional perfect sub-window scoring: JUDGE_PERFECT_EN.
module lane_hit_judge #(
    parameter int Y_W          = 10,
    parameter int HIT_Y_MIN    = 400,
    parameter int HIT_Y_MAX    = 460,
    parameter int SCORE_W      = 16,
    parameter int COMBO_W      = 8,
    parameter int FLASH_FRAMES = 8,
    parameter int PERF_Y_MIN   = 425,
    parameter int PERF_Y_MAX   = 435
) (
    input  logic               CLOCK_25,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               en_regions,
    input  logic [3:0]         green_region,
    input  logic [3:0]         note_valid,
    input  logic [4*Y_W-1:0]   note_y,
    output logic [3:0]         note_consume,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [3:0]         hit_flash,
    output logic [3:0]         miss_flash,
`ifdef JUDGE_PERFECT_EN
    output logic [3:0]         perfect_flash,
`endif
    output logic               busy,
    output logic               overrun
);

    localparam int FL_W  = $clog2(FLASH_FRAMES + 1);
    // two spare bits hold score + combo + bonus without wrapping (combo is never wider than score)
    localparam int SUM_W = SCORE_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;

    localparam logic [FL_W-1:0]  FLASH_LOAD = FL_W'(FLASH_FRAMES);
    localparam logic [FL_W-1:0]  FLASH_ONE  = FL_W'(1);
    localparam logic [Y_W-1:0]   WIN_LO     = Y_W'(HIT_Y_MIN);
    localparam logic [Y_W-1:0]   WIN_HI     = Y_W'(HIT_Y_MAX);
    localparam logic [Y_W-1:0]   PERF_LO    = Y_W'(PERF_Y_MIN);
    localparam logic [Y_W-1:0]   PERF_HI    = Y_W'(PERF_Y_MAX);
    localparam logic [SUM_W-1:0] PTS_HIT    = SUM_W'(10);
    localparam logic [SUM_W-1:0] PTS_PERF   = SUM_W'(20);
    localparam logic [SUM_W-1:0] SCORE_CAP  = {2'b00, {SCORE_W{1'b1}}};
`ifdef JUDGE_PERFECT_EN
    localparam logic PERF_EN = 1'b1;
`else
    localparam logic PERF_EN = 1'b0;
`endif

    logic [2:0]         state_r;
    logic [1:0]         lane_r;
    logic [3:0]         prev_region_r;
    logic [3:0]         press_r;
    logic [3:0]         valid_r;
    logic [4*Y_W-1:0]   note_y_r;
    logic [SCORE_W-1:0] score_r;
    logic [COMBO_W-1:0] combo_r;
    logic [3:0]         consume_r;
    logic [FL_W-1:0]    hit_cnt_r  [4];
    logic [FL_W-1:0]    miss_cnt_r [4];
    logic [3:0]         hit_flash_r;
    logic [3:0]         miss_flash_r;
    logic               busy_r;
    logic               overrun_r;
`ifdef JUDGE_PERFECT_EN
    logic [FL_W-1:0]    perf_cnt_r [4];
    logic [3:0]         perf_flash_r;
`endif

    logic [3:0]         region_s;
    logic [Y_W-1:0]     lane_y_s;
    logic               in_win_s;
    logic               perf_s;
    logic               hit_s;
    logic               miss_s;
    logic               ghost_s;
    logic [SUM_W-1:0]   bonus_s;
    logic [SUM_W-1:0]   score_sum_s;
    logic [SCORE_W-1:0] score_next_s;
    logic [COMBO_W-1:0] combo_inc_s;

    // Judgement of the lane currently under evaluation, with saturating score/combo updates
    always_comb begin
        region_s    = en_regions ? green_region : 4'b0000;
        lane_y_s    = note_y_r[int'(lane_r)*Y_W +: Y_W];
        in_win_s    = valid_r[lane_r] && (lane_y_s >= WIN_LO) && (lane_y_s <= WIN_HI);
        perf_s      = PERF_EN && (lane_y_s >= PERF_LO) && (lane_y_s <= PERF_HI);
        hit_s       = press_r[lane_r] && in_win_s;
        miss_s      = valid_r[lane_r] && (lane_y_s > WIN_HI);
        ghost_s     = press_r[lane_r] && !in_win_s;
        bonus_s     = perf_s ? PTS_PERF : PTS_HIT;
        score_sum_s = {2'b00, score_r} + SUM_W'(combo_r) + bonus_s;
        if (score_sum_s > SCORE_CAP) begin
            score_next_s = {SCORE_W{1'b1}};
        end else begin
            score_next_s = score_sum_s[SCORE_W-1:0];
        end
        if (combo_r == {COMBO_W{1'b1}}) begin
            combo_inc_s = combo_r;
        end else begin
            combo_inc_s = combo_r + COMBO_W'(1);
        end
    end

    // Frame FSM: sample, judge lanes 0..3 serially, then return to idle
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            state_r       <= S_IDLE;
            lane_r        <= 2'd0;
            prev_region_r <= 4'b0000;
            press_r       <= 4'b0000;
            valid_r       <= 4'b0000;
            note_y_r      <= '0;
            score_r       <= '0;
            combo_r       <= '0;
            consume_r     <= 4'b0000;
            hit_flash_r   <= 4'b0000;
            miss_flash_r  <= 4'b0000;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hit_cnt_r[i]  <= '0;
                miss_cnt_r[i] <= '0;
            end
`ifdef JUDGE_PERFECT_EN
            perf_flash_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                perf_cnt_r[i] <= '0;
            end
`endif
        end else begin
            consume_r <= 4'b0000;
            if (frame_tick && (state_r != S_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                S_IDLE: begin
                    if (frame_tick) begin
                        state_r <= S_SAMPLE;
                        busy_r  <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    press_r       <= region_s & ~prev_region_r;
                    prev_region_r <= region_s;
                    valid_r       <= note_valid;
                    note_y_r      <= note_y;
                    lane_r        <= 2'd0;
                    state_r       <= S_EVAL;
                    for (int i = 0; i < 4; i++) begin
                        if (hit_cnt_r[i] != '0) begin
                            hit_cnt_r[i]   <= hit_cnt_r[i] - FLASH_ONE;
                            hit_flash_r[i] <= (hit_cnt_r[i] != FLASH_ONE);
                        end
                        if (miss_cnt_r[i] != '0) begin
                            miss_cnt_r[i]   <= miss_cnt_r[i] - FLASH_ONE;
                            miss_flash_r[i] <= (miss_cnt_r[i] != FLASH_ONE);
                        end
`ifdef JUDGE_PERFECT_EN
                        if (perf_cnt_r[i] != '0) begin
                            perf_cnt_r[i]   <= perf_cnt_r[i] - FLASH_ONE;
                            perf_flash_r[i] <= (perf_cnt_r[i] != FLASH_ONE);
                        end
`endif
                    end
                end
                S_EVAL: begin
                    if (hit_s) begin
                        score_r               <= score_next_s;
                        combo_r               <= combo_inc_s;
                        consume_r[lane_r]     <= 1'b1;
                        hit_cnt_r[lane_r]     <= FLASH_LOAD;
                        hit_flash_r[lane_r]   <= 1'b1;
                        miss_cnt_r[lane_r]    <= '0;
                        miss_flash_r[lane_r]  <= 1'b0;
`ifdef JUDGE_PERFECT_EN
                        perf_cnt_r[lane_r]    <= perf_s ? FLASH_LOAD : '0;
                        perf_flash_r[lane_r]  <= perf_s;
`endif
                    end else if (miss_s) begin
                        combo_r               <= '0;
                        consume_r[lane_r]     <= 1'b1;
                        miss_cnt_r[lane_r]    <= FLASH_LOAD;
                        miss_flash_r[lane_r]  <= 1'b1;
                        hit_cnt_r[lane_r]     <= '0;
                        hit_flash_r[lane_r]   <= 1'b0;
`ifdef JUDGE_PERFECT_EN
                        perf_cnt_r[lane_r]    <= '0;
                        perf_flash_r[lane_r]  <= 1'b0;
`endif
                    end else if (ghost_s) begin
                        combo_r <= '0;
                    end
                    if (lane_r == 2'd3) begin
                        state_r <= S_DONE;
                    end else begin
                        lane_r <= lane_r + 2'd1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign note_consume = consume_r;
    assign score        = score_r;
    assign combo        = combo_r;
    assign hit_flash    = hit_flash_r;
    assign miss_flash   = miss_flash_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;
`ifdef JUDGE_PERFECT_EN
    assign perfect_flash = perf_flash_r;
`endif

endmodule
